// File: rtl/fft_iter_if.sv
// Sample-in / bin-out handshake bundle for the iterative FFT engine.
interface fft_iter_if #(
  parameter int DATA_W = 24,
  parameter int IDX_W  = 3
);
  logic                     mode_inv;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic [IDX_W-1:0]         out_index;
  logic                     out_last;
  logic                     busy;
  logic                     ovf;

  modport master (
    output mode_inv, in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last, busy, ovf
  );

  modport slave (
    input  mode_inv, in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last, busy, ovf
  );
endinterface

// File: rtl/fft_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT: serial load in bit-reversed order,
// one shared butterfly per cycle, serial unload in natural order.
module fft_iter #(
  parameter int POINTS   = 8,
  parameter int DATA_W   = 24,
  parameter int TW_W     = 16,
  parameter int SCALE_EN = 1
) (
  input  logic      clk,
  input  logic      rst,
  fft_iter_if.slave bus
);
  localparam int L      = $clog2(POINTS);
  localparam int HALF   = POINTS / 2;
  localparam int T_W    = L - 1;
  localparam int S_W    = $clog2(L + 1);
  localparam int SUM_W  = DATA_W + 2;
  localparam int PROD_W = DATA_W + TW_W + 1;
  localparam int SHIFT  = TW_W - 3;
  localparam logic signed [PROD_W-1:0] RND   = PROD_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0]  MAX_V = SUM_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0]  MIN_V = ~MAX_V;

  typedef enum logic [1:0] {LOAD, CALC, FLUSH, UNLOAD} state_e;

  function automatic int tw_val(input int t, input bit imag);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(t) / real'(POINTS);
    v   = (imag ? -$sin(ang) : $cos(ang)) * real'(1 << SHIFT);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int b = 0; b < L; b++) r[b] = v[L-1-b];
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] clip(input logic signed [SUM_W-1:0] v);
    if (v > MAX_V) return {1'b0, {(DATA_W-1){1'b1}}};
    if (v < MIN_V) return {1'b1, {(DATA_W-1){1'b0}}};
    return v[DATA_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [SUM_W-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  logic signed [TW_W-1:0] tw_re_tab [HALF];
  logic signed [TW_W-1:0] tw_im_tab [HALF];

  // Twiddle constants are folded at elaboration; imag already holds -sin.
  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam int TRE = tw_val(g, 1'b0);
    localparam int TIM = tw_val(g, 1'b1);
    assign tw_re_tab[g] = TW_W'(TRE);
    assign tw_im_tab[g] = TW_W'(TIM);
  end

  logic signed [DATA_W-1:0] mem_re [POINTS];
  logic signed [DATA_W-1:0] mem_im [POINTS];

  state_e                   state_q, state_d;
  logic [L-1:0]             cnt_q, cnt_d;
  logic [S_W-1:0]           s_q, s_d;
  logic [T_W-1:0]           j_q, j_d;
  logic                     inv_q, inv_d;
  logic                     ovf_q, ovf_d;
  logic                     wb_en_q, wb_en_d;
  logic [L-1:0]             wb_p_q, wb_p_d, wb_q_q, wb_q_d;
  logic signed [DATA_W-1:0] wb_pr_q, wb_pr_d, wb_pi_q, wb_pi_d;
  logic signed [DATA_W-1:0] wb_qr_q, wb_qr_d, wb_qi_q, wb_qi_d;

  logic [L-1:0]             j_ext, lo_mask, bf_p, bf_q;
  logic [T_W-1:0]           bf_t;
  logic signed [DATA_W-1:0] xp_re, xp_im, xq_re, xq_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PROD_W-1:0] m_re, m_im;
  logic signed [SUM_W-1:0]  mt_re, mt_im, sum_pr, sum_pi, dif_qr, dif_qi;
  logic                     sat_any, load_we, in_hs, out_hs;

  // Butterfly addressing for pair j of stage s, then the complex multiply-add.
  always_comb begin
    j_ext   = {1'b0, j_q};
    lo_mask = (L'(1) << s_q) - L'(1);
    bf_p    = ((j_ext >> s_q) << (s_q + S_W'(1))) | (j_ext & lo_mask);
    bf_q    = bf_p + (L'(1) << s_q);
    bf_t    = T_W'((j_ext & lo_mask) << (S_W'(L - 1) - s_q));
    xp_re   = mem_re[bf_p];
    xp_im   = mem_im[bf_p];
    xq_re   = mem_re[bf_q];
    xq_im   = mem_im[bf_q];
    w_re    = tw_re_tab[bf_t];
    w_im    = inv_q ? -tw_im_tab[bf_t] : tw_im_tab[bf_t];
    m_re    = PROD_W'(xq_re) * PROD_W'(w_re) - PROD_W'(xq_im) * PROD_W'(w_im);
    m_im    = PROD_W'(xq_re) * PROD_W'(w_im) + PROD_W'(xq_im) * PROD_W'(w_re);
    mt_re   = SUM_W'((m_re + RND) >>> SHIFT);
    mt_im   = SUM_W'((m_im + RND) >>> SHIFT);
    sum_pr  = SUM_W'(xp_re) + mt_re;
    sum_pi  = SUM_W'(xp_im) + mt_im;
    dif_qr  = SUM_W'(xp_re) - mt_re;
    dif_qi  = SUM_W'(xp_im) - mt_im;
    if (SCALE_EN != 0) begin
      sum_pr = sum_pr >>> 1;
      sum_pi = sum_pi >>> 1;
      dif_qr = dif_qr >>> 1;
      dif_qi = dif_qi >>> 1;
    end
    sat_any = clipped(sum_pr) | clipped(sum_pi) | clipped(dif_qr) | clipped(dif_qi);
  end

  assign in_hs  = bus.in_valid & (state_q == LOAD);
  assign out_hs = bus.out_ready & (state_q == UNLOAD);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    j_d     = j_q;
    inv_d   = inv_q;
    ovf_d   = ovf_q;
    load_we = 1'b0;
    wb_en_d = 1'b0;
    wb_p_d  = bf_p;
    wb_q_d  = bf_q;
    wb_pr_d = clip(sum_pr);
    wb_pi_d = clip(sum_pi);
    wb_qr_d = clip(dif_qr);
    wb_qi_d = clip(dif_qi);
    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + L'(1);
          if (cnt_q == '0) begin
            inv_d = bus.mode_inv;
            ovf_d = 1'b0;
          end
          if (cnt_q == L'(POINTS - 1)) begin
            state_d = CALC;
            s_d     = '0;
            j_d     = '0;
          end
        end
      end
      CALC: begin
        wb_en_d = 1'b1;
        if (sat_any) ovf_d = 1'b1;
        j_d = j_q + T_W'(1);
        if (j_q == '1) state_d = FLUSH;
      end
      FLUSH: begin
        // The last write of the stage lands here, so the next stage reads settled data.
        if (s_q == S_W'(L - 1)) begin
          state_d = UNLOAD;
          cnt_d   = '0;
        end else begin
          state_d = CALC;
          s_d     = s_q + S_W'(1);
          j_d     = '0;
        end
      end
      UNLOAD: begin
        if (out_hs) begin
          cnt_d = cnt_q + L'(1);
          if (cnt_q == '1) state_d = LOAD;
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      s_q     <= '0;
      j_q     <= '0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wb_en_q <= 1'b0;
      wb_p_q  <= '0;
      wb_q_q  <= '0;
      wb_pr_q <= '0;
      wb_pi_q <= '0;
      wb_qr_q <= '0;
      wb_qi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      j_q     <= j_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
      wb_en_q <= wb_en_d;
      wb_p_q  <= wb_p_d;
      wb_q_q  <= wb_q_d;
      wb_pr_q <= wb_pr_d;
      wb_pi_q <= wb_pi_d;
      wb_qr_q <= wb_qr_d;
      wb_qi_q <= wb_qi_d;
    end
  end

  // NOTE: the sample memory is deliberately not reset; every location is written before it is read.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_re[bitrev(cnt_q)] <= bus.in_real;
      mem_im[bitrev(cnt_q)] <= bus.in_imag;
    end
    if (wb_en_q) begin
      mem_re[wb_p_q] <= wb_pr_q;
      mem_im[wb_p_q] <= wb_pi_q;
      mem_re[wb_q_q] <= wb_qr_q;
      mem_im[wb_q_q] <= wb_qi_q;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.busy      = (state_q == CALC) || (state_q == FLUSH);
  assign bus.out_valid = (state_q == UNLOAD);
  assign bus.out_real  = (state_q == UNLOAD) ? mem_re[cnt_q] : '0;
  assign bus.out_imag  = (state_q == UNLOAD) ? mem_im[cnt_q] : '0;
  assign bus.out_index = (state_q == UNLOAD) ? cnt_q : '0;
  assign bus.out_last  = (state_q == UNLOAD) && (cnt_q == '1);
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fft_iter.sv
// Directed bench for fft_iter (8 points): textbook FFT model, literal pins,
// and a per-cycle output comparator on the unscaled instance.
module tb_fft_iter;
  localparam int N = 8;
  localparam int L = 3;
  localparam longint MAXV = 8388607;
  localparam longint MINV = -8388608;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_iter_if #(.DATA_W(24), .IDX_W(L)) bus0 ();
  fft_iter_if #(.DATA_W(24), .IDX_W(L)) bus1 ();

  fft_iter #(.POINTS(N), .DATA_W(24), .TW_W(16), .SCALE_EN(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fft_iter #(.POINTS(N), .DATA_W(24), .TW_W(16), .SCALE_EN(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     c0 = 0;
  int     exp_idx = N;
  bit     exp_ovf = 1'b0;
  longint fr_re [N];
  longint fr_im [N];
  longint exp_re [N];
  longint exp_im [N];
  longint mod_re [N];
  longint mod_im [N];
  bit     mod_sat;
  longint tw_re [N/2];
  longint tw_im [N/2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint tw(input int t, input bit im);
    real a;
    real v;
    a = 2.0 * PI * real'(t) / real'(N);
    v = im ? -$sin(a) * 8192.0 : $cos(a) * 8192.0;
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
  endfunction

  function automatic int brev(input int n);
    int r = 0;
    for (int b = 0; b < L; b++) r |= ((n >> b) & 1) << (L - 1 - b);
    return r;
  endfunction

  // Textbook radix-2 DIT on arrays with the block's rounding and saturation rules.
  function automatic void fft_model(input longint xr[N], input longint xi[N], input bit inv,
                                    input bit scale, output longint yr[N], output longint yi[N],
                                    output bit sat);
    longint ar [N];
    longint ai [N];
    sat = 1'b0;
    for (int n = 0; n < N; n++) begin
      ar[brev(n)] = xr[n];
      ai[brev(n)] = xi[n];
    end
    for (int s = 0; s < L; s++) begin
      for (int g = 0; g < N; g += (2 << s)) begin
        for (int i = 0; i < (1 << s); i++) begin
          int p, q, t;
          longint wr, wi, mr, mi;
          longint v [4];
          p  = g + i;
          q  = p + (1 << s);
          t  = i * (N >> (s + 1));
          wr = tw_re[t];
          wi = inv ? -tw_im[t] : tw_im[t];
          mr = (ar[q] * wr - ai[q] * wi + 4096) >>> 13;
          mi = (ar[q] * wi + ai[q] * wr + 4096) >>> 13;
          v[0] = ar[p] + mr;
          v[1] = ai[p] + mi;
          v[2] = ar[p] - mr;
          v[3] = ai[p] - mi;
          for (int e = 0; e < 4; e++) begin
            if (scale) v[e] = v[e] >>> 1;
            if (v[e] > MAXV) begin v[e] = MAXV; sat = 1'b1; end
            else if (v[e] < MINV) begin v[e] = MINV; sat = 1'b1; end
          end
          ar[p] = v[0]; ai[p] = v[1]; ar[q] = v[2]; ai[q] = v[3];
        end
      end
    end
    yr = ar;
    yi = ai;
  endfunction

  // Comparator for the unscaled instance: every valid cycle, plus hold-while-stalled.
  bit     stalled = 1'b0;
  longint prev_re, prev_im, prev_idx;
  always @(negedge clk) begin
    if (!rst && bus0.out_valid) begin
      if (exp_idx >= N) check("extra_bin", exp_idx, N - 1);
      else begin
        check("bin_re", bus0.out_real, exp_re[exp_idx]);
        check("bin_im", bus0.out_imag, exp_im[exp_idx]);
        check("bin_index", bus0.out_index, exp_idx);
        check("bin_last", bus0.out_last, (exp_idx == N - 1) ? 1 : 0);
        check("bin_ovf", bus0.ovf, exp_ovf);
      end
      if (stalled) begin
        check("stall_re", bus0.out_real, prev_re);
        check("stall_im", bus0.out_imag, prev_im);
        check("stall_idx", bus0.out_index, prev_idx);
      end
      stalled  = !bus0.out_ready;
      prev_re  = bus0.out_real;
      prev_im  = bus0.out_imag;
      prev_idx = bus0.out_index;
      if (bus0.out_ready) exp_idx++;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send0(input bit inv, input bit gaps, input bit junk);
    for (int n = 0; n < N; n++) begin
      if (gaps && (n % 2 == 1)) begin
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus0.in_valid = 1'b1;
      bus0.mode_inv = inv;
      bus0.in_real  = fr_re[n][23:0];
      bus0.in_imag  = fr_im[n][23:0];
      for (int w = 0; w < 300 && !bus0.in_ready; w++) begin
        @(posedge clk); #1;
      end
      if (!bus0.in_ready) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      if (n == 0) check("ovf_clear_first_hs", bus0.ovf, 0);
    end
    c0 = cyc;
    bus0.in_valid = 1'b0;
    check("busy_calc", bus0.busy, 1);
    check("in_ready_calc", bus0.in_ready, 0);
    if (junk) begin
      for (int c = 0; c < 4; c++) begin
        bus0.in_valid = 1'b1;
        bus0.in_real  = 24'sd777;
        @(posedge clk); #1;
        check("in_ready_busy", bus0.in_ready, 0);
      end
      bus0.in_valid = 1'b0;
    end
  endtask

  task automatic recv0(input bit bp, input bit chk_lat);
    bit seen = 1'b0;
    for (int c = 0; c < 400 && exp_idx < N; c++) begin
      bus0.out_ready = bp ? (c % 3 == 0) : 1'b1;
      if (!seen && bus0.out_valid) begin
        seen = 1'b1;
        if (chk_lat) check("latency", cyc - c0 + 1, 16);
      end
      @(posedge clk); #1;
    end
    if (chk_lat && !seen) check("latency_never", 0, 16);
    check("bins_received", exp_idx, N);
    check("valid_drop", bus0.out_valid, 0);
    bus0.out_ready = 1'b0;
  endtask

  task automatic start_frame(input bit use_model, input bit inv);
    fft_model(fr_re, fr_im, inv, 1'b0, mod_re, mod_im, mod_sat);
    if (use_model) begin
      exp_re  = mod_re;
      exp_im  = mod_im;
      exp_ovf = mod_sat;
    end
    exp_idx = 0;
  endtask

  task automatic run1(input longint er[N], input longint ei[N]);
    int got = 0;
    for (int n = 0; n < N; n++) begin
      bus1.in_valid = 1'b1;
      bus1.in_real  = fr_re[n][23:0];
      bus1.in_imag  = fr_im[n][23:0];
      for (int w = 0; w < 300 && !bus1.in_ready; w++) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    for (int c = 0; c < 200 && got < N; c++) begin
      if (bus1.out_valid) begin
        check("s1_re", bus1.out_real, er[got]);
        check("s1_im", bus1.out_imag, ei[got]);
        check("s1_index", bus1.out_index, got);
        got++;
      end
      @(posedge clk); #1;
    end
    check("s1_bins", got, N);
    bus1.out_ready = 1'b0;
  endtask

  task automatic fill(input longint re_all, input longint re0);
    for (int n = 0; n < N; n++) begin
      fr_re[n] = (n == 0) ? re0 : re_all;
      fr_im[n] = 0;
    end
  endtask

  task automatic expect_lit(input longint y0, input longint rest, input bit ovf);
    for (int k = 0; k < N; k++) begin
      exp_re[k] = (k == 0) ? y0 : rest;
      exp_im[k] = 0;
    end
    exp_ovf = ovf;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    longint tone_re [N] = '{4096, 2896, 0, -2896, -4096, -2896, 0, 2896};
    longint tone_im [N] = '{0, 2896, 4096, 2896, 0, -2896, -4096, -2896};
    longint l_re [N];
    longint l_im [N];
    bus0.in_valid = 0; bus0.mode_inv = 0; bus0.in_real = '0; bus0.in_imag = '0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.mode_inv = 0; bus1.in_real = '0; bus1.in_imag = '0; bus1.out_ready = 0;
    for (int t = 0; t < N / 2; t++) begin
      tw_re[t] = tw(t, 1'b0);
      tw_im[t] = tw(t, 1'b1);
    end
    check("model_tw1_re", tw_re[1], 5793);
    check("model_tw1_im", tw_im[1], -5793);

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_ovf", bus0.ovf, 0);
    check("rst_out_real", bus0.out_real, 0);
    check("rst_out_index", bus0.out_index, 0);
    check("rst_out_last", bus0.out_last, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Impulse
    fill(0, 1000);
    start_frame(1'b0, 1'b0);
    expect_lit(1000, 1000, 1'b0);
    check("model_impulse_y3", mod_re[3], 1000);
    send0(1'b0, 1'b0, 1'b0);
    recv0(1'b0, 1'b1);

    // DC, unscaled
    fill(1000, 1000);
    start_frame(1'b0, 1'b0);
    expect_lit(8000, 0, 1'b0);
    check("model_dc_y0", mod_re[0], 8000);
    send0(1'b0, 1'b0, 1'b0);
    recv0(1'b0, 1'b0);

    // DC, scaled instance
    fill(8000, 8000);
    fft_model(fr_re, fr_im, 1'b0, 1'b1, l_re, l_im, mod_sat);
    check("model_dc_scaled_y0", l_re[0], 8000);
    check("model_dc_scaled_y5", l_re[5], 0);
    for (int k = 0; k < N; k++) begin
      l_re[k] = (k == 0) ? 8000 : 0;
      l_im[k] = 0;
    end
    run1(l_re, l_im);

    // Tone, forward then inverse
    fr_re = tone_re;
    fr_im = tone_im;
    start_frame(1'b1, 1'b0);
    check("model_tone_peak", (mod_re[1] >= 32764 && mod_re[1] <= 32772) ? 1 : 0, 1);
    check("model_tone_floor", (mod_re[4] >= -4 && mod_re[4] <= 4 && mod_im[6] >= -4 && mod_im[6] <= 4) ? 1 : 0, 1);
    send0(1'b0, 1'b0, 1'b0);
    recv0(1'b0, 1'b0);
    start_frame(1'b1, 1'b1);
    check("model_itone_peak", (mod_re[7] >= 32764 && mod_re[7] <= 32772) ? 1 : 0, 1);
    send0(1'b1, 1'b0, 1'b0);
    recv0(1'b0, 1'b0);

    // Full-scale DC saturates, then a zero frame clears the flag
    fill(MAXV, MAXV);
    start_frame(1'b0, 1'b0);
    expect_lit(MAXV, 0, 1'b1);
    check("model_sat_flag", mod_sat, 1);
    send0(1'b0, 1'b0, 1'b0);
    recv0(1'b0, 1'b0);
    check("ovf_sticky", bus0.ovf, 1);
    fill(0, 0);
    start_frame(1'b0, 1'b0);
    expect_lit(0, 0, 1'b0);
    send0(1'b0, 1'b0, 1'b0);
    recv0(1'b0, 1'b0);

    // Impulse with input gaps, ignored input during CALC and output backpressure
    fill(0, 1000);
    start_frame(1'b0, 1'b0);
    expect_lit(1000, 1000, 1'b0);
    send0(1'b0, 1'b1, 1'b1);
    recv0(1'b1, 1'b0);

    // Pseudo-random frame against the model
    for (int n = 0; n < N; n++) begin
      fr_re[n] = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
      fr_im[n] = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
    end
    start_frame(1'b1, 1'b0);
    send0(1'b0, 1'b0, 1'b0);
    recv0(1'b1, 1'b0);

    // Reset in the middle of stage 1 of a saturating frame
    fill(MAXV, MAXV);
    send0(1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", bus0.busy, 1);
    check("mid_ovf_set", bus0.ovf, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus0.out_valid, 0);
    check("mid_rst_in_ready", bus0.in_ready, 1);
    check("mid_rst_busy", bus0.busy, 0);
    check("mid_rst_ovf", bus0.ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill(0, 1000);
    start_frame(1'b0, 1'b0);
    expect_lit(1000, 1000, 1'b0);
    send0(1'b0, 1'b0, 1'b0);
    recv0(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fft_iter.md
Name: fft_iter

Overview:
- Parametrised, iterative, in-place radix-2 decimation-in-time FFT/IFFT engine with a single shared butterfly.
- Generalises the fixed 8-point parallel FFT to POINTS points, configurable widths, selectable inverse mode and per-stage scaling.
- Samples stream in and out serially over valid/ready handshakes, so the block sits between a sample source and a spectrum consumer.
- Trades throughput for area: one butterfly per cycle.

Parameters:
POINTS, 8, transform length; power of two, 4..1024; L = log2(POINTS)
DATA_W, 24, signed sample width, real and imag each
TW_W, 16, signed twiddle width; unity = 2^(TW_W-3) (0x2000 for 16)
SCALE_EN, 1, 1: every stage result >>>1 (total 1/POINTS); 0: saturate, no scaling

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mode_inv  in  1  0 forward, 1 inverse; sampled with the first sample of each frame
in_valid  in  1  input sample valid
in_ready  out  1  block accepts a sample
in_real  in  DATA_W  input sample real, natural order
in_imag  in  DATA_W  input sample imag
out_valid  out  1  output bin valid
out_ready  in  1  consumer accepts a bin
out_real  out  DATA_W  output bin real, natural order
out_imag  out  DATA_W  output bin imag
out_index  out  L  bin index of current output
out_last  out  1  high with bin POINTS-1
busy  out  1  high in CALC/FLUSH
ovf  out  1  sticky saturation flag for the current frame

Behaviour:
- States: LOAD, CALC, FLUSH, UNLOAD.
- Reset (async, any state) -> LOAD, counters 0. Outputs: in_ready=1, out_valid=0, out_real/out_imag/out_index/out_last=0, busy=0, ovf=0. Sample memory is not reset. Any frame in progress is discarded.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid&in_ready) writes the sample to mem[bitrev_L(cnt)], then cnt++.
  - On the cnt==0 handshake: latch mode_inv and clear ovf.
  - On the cnt==POINTS-1 handshake -> CALC, s=0, j=0.
- CALC:
  - in_ready=0, busy=1.
  - Each cycle, issue butterfly j of stage s:
    - p = ((j>>s)<<(s+1)) + (j & (2^s-1)); q = p + 2^s
    - twiddle index t = (j & (2^s-1)) << (L-1-s)
  - Reads are combinational from mem. Results are registered and written back to mem[p], mem[q] on the following cycle.
  - After j=POINTS/2-1 -> FLUSH.
- FLUSH:
  - One cycle; completes the last write of the stage, avoiding inter-stage read-after-write hazards.
  - If s<L-1: s++, j=0 -> CALC. Otherwise -> UNLOAD, k=0.
- UNLOAD:
  - out_valid=1; out_real/out_imag = mem[k]; out_index=k; out_last = (k==POINTS-1).
  - Outputs are held stable while out_valid&!out_ready.
  - k++ on each handshake. After the out_last handshake -> LOAD; out_valid drops the next cycle.
- Latency: from the last input handshake (cycle 0), out_valid first rises at cycle L*(POINTS/2+1)+1 (16 for POINTS=8). Frame period is at least POINTS + L*(POINTS/2+1) + POINTS cycles; LOAD and UNLOAD do not overlap.
- Twiddles:
  - W_t = round(cos(2πt/POINTS)·2^(TW_W-3)) - j·round(sin(2πt/POINTS)·2^(TW_W-3)), for t = 0..POINTS/2-1.
  - Table is constant, computed at elaboration.
  - Inverse mode uses conj(W_t), i.e. the imag part is negated.
- Butterfly arithmetic:
  - m = xq·W at full precision; m' = (m + 2^(TW_W-4)) >>> (TW_W-3), round half up.
  - yp = xp + m', yq = xp - m', computed at DATA_W+2 bits.
  - SCALE_EN=1: result >>>1 (floor), then saturate to DATA_W. SCALE_EN=0: saturate to DATA_W.
  - Any saturation sets ovf; ovf stays high until the next frame's first input handshake or reset.
- Simultaneous events: in_valid while not in LOAD is ignored (in_ready=0). out_ready while not in UNLOAD is ignored.

Test Plan:
1. POINTS=8, SCALE_EN=0, forward; impulse x0=1000+0j, rest 0 -> bins 0..7 all 1000+0j, ovf=0; out_valid first rises 16 cycles after the last input handshake; out_index 0..7, out_last on 7.
2. SCALE_EN=1; DC input, all samples 8000+0j -> y0=8000+0j, y1..y7=0; with SCALE_EN=0 and all 1000 -> y0=8000, others 0.
3. SCALE_EN=0; tone x_n = 4096·(cos(2πn/8) + j·sin(2πn/8)) -> forward: y1≈32768+0j, others |·|≤4 LSB; same input with mode_inv=1 -> y7≈32768, others ≤4 LSB.
4. SCALE_EN=0; all samples 0x7FFFFF+0j -> y0=0x7FFFFF (saturated), ovf=1; next frame of zeros -> ovf clears at its first handshake, all bins 0.
5. Backpressure: out_ready toggles 1,0,0,1,... and in_valid gaps in LOAD -> no bin dropped or duplicated; outputs stable while stalled; results identical to scenario 1.
6. Assert rst for 1 cycle mid-CALC (stage 1) -> same cycle: out_valid=0, in_ready=1, busy=0, ovf=0; a new impulse frame then yields scenario-1 results.
